wb_mem_arb: RTL

Two-master Wishbone arbiter and address decoder that sits directly upstream of the QSPI memory adapter. Merges the CPU instruction bus (read-only) and data bus into the adapter's single memory port. Decodes ROM/RAM from the byte address and drives the adapter's `sel_rom_ram_i`, holding it stable for the whole strobe. Holds a one-word fetch buffer so straight-line refetches of the last instruction word skip the QSPI transaction, and drops ROM writes so they never reach the adapter.

---
 rtl/wb_mem_pkg.sv | 41 ++++
 rtl/wb_mem_fetch_buf.sv | 39 +++
 rtl/wb_mem_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the Wishbone memory arbiter.
// Region decode, FSM state encoding and fetch-buffer tag width.
package wb_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_I,
        S_MEM_D,
        S_LOCAL_I,
        S_LOCAL_D
    } state_e;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_NONE
    } region_e;

    localparam logic [7:0] ROM_PAGE_DEF = 8'h00;
    localparam logic [7:0] RAM_PAGE_DEF = 8'h01;

    // Tag is {sel, word address}.
    localparam int TAG_W = 23;

    function automatic region_e decode_region(
        input logic [31:0] adr,
        input logic [7:0]  rom_page,
        input logic [7:0]  ram_page
    );
        region_e r;
        if (adr[31:24] == rom_page) begin
            r = REG_ROM;
        end else if (adr[31:24] == ram_page) begin
            r = REG_RAM;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_mem_fetch_buf.sv
// Single-word instruction fetch buffer with tag compare.
// Load on a completed fetch, drop on a matching data write.
module wb_mem_fetch_buf
    import wb_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TAG_W-1:0] load_tag_i,
    input  logic [31:0]      load_dat_i,
    input  logic             inv_i,
    input  logic [TAG_W-1:0] inv_tag_i,
    input  logic [TAG_W-1:0] look_tag_i,
    output logic             hit_o,
    output logic [31:0]      dat_o
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            dat_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= load_tag_i;
            dat_q   <= load_dat_i;
        end else if (inv_i && (tag_q == inv_tag_i)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o = valid_q && (tag_q == look_tag_i);
    assign dat_o = dat_q;

endmodule

// File: rtl/wb_mem_arb.sv
// Two-master Wishbone arbiter and ROM/RAM decoder in front of
// the QSPI memory adapter, with a one-word fetch buffer.
module wb_mem_arb
    import wb_mem_pkg::*;
#(
    parameter logic [7:0] ROM_PAGE = ROM_PAGE_DEF,
    parameter logic [7:0] RAM_PAGE = RAM_PAGE_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ibus_stb_i,
    input  logic [31:0] ibus_adr_i,
    output logic        ibus_ack_o,
    output logic [31:0] ibus_dat_o,
    input  logic        dbus_stb_i,
    input  logic        dbus_we_i,
    input  logic [3:0]  dbus_be_i,
    input  logic [31:0] dbus_adr_i,
    input  logic [31:0] dbus_dat_i,
    output logic        dbus_ack_o,
    output logic [31:0] dbus_dat_o,
    output logic        mem_sel_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_dat_o,
    output logic [21:0] mem_adr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i
);

    state_e state_q, state_d;
    logic   last_d_q;
    logic   loc_hit_q, loc_hit_d;

    logic        sel_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] dat_q;
    logic [21:0] adr_q;

    logic grant, grant_d;
    logic req_i, req_d;
    logic buf_inv, buf_load;
    logic buf_hit;
    logic [31:0] buf_dat;

    region_e i_reg, d_reg;
    logic i_map, d_map;
    logic [TAG_W-1:0] i_tag, d_tag;

    logic unused_lsb;
    assign unused_lsb = ^{ibus_adr_i[1:0], dbus_adr_i[1:0]};

    assign i_reg = decode_region(ibus_adr_i, ROM_PAGE, RAM_PAGE);
    assign d_reg = decode_region(dbus_adr_i, ROM_PAGE, RAM_PAGE);
    assign i_map = (i_reg != REG_NONE);
    assign d_map = (d_reg != REG_NONE);
    assign i_tag = {i_reg == REG_RAM, ibus_adr_i[23:2]};
    assign d_tag = {d_reg == REG_RAM, dbus_adr_i[23:2]};

    wb_mem_fetch_buf u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (buf_load),
        .load_tag_i ({sel_q, adr_q}),
        .load_dat_i (mem_dat_i),
        .inv_i      (buf_inv),
        .inv_tag_i  (d_tag),
        .look_tag_i (i_tag),
        .hit_o      (buf_hit),
        .dat_o      (buf_dat)
    );

    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_d    = 1'b0;
        req_i      = 1'b0;
        req_d      = 1'b0;
        buf_inv    = 1'b0;
        buf_load   = 1'b0;
        loc_hit_d  = 1'b0;
        ibus_ack_o = 1'b0;
        ibus_dat_o = '0;
        dbus_ack_o = 1'b0;
        dbus_dat_o = '0;
        unique case (state_q)
            S_IDLE: begin
                // On a collision, the master not served last wins.
                if (ibus_stb_i && (!dbus_stb_i || last_d_q)) begin
                    grant     = 1'b1;
                    loc_hit_d = i_map && buf_hit;
                    if (!i_map || buf_hit) begin
                        state_d = S_LOCAL_I;
                    end else begin
                        state_d = S_MEM_I;
                        req_i   = 1'b1;
                    end
                end else if (dbus_stb_i) begin
                    grant   = 1'b1;
                    grant_d = 1'b1;
                    if (!d_map || (dbus_we_i && d_reg == REG_ROM)) begin
                        state_d = S_LOCAL_D;
                    end else begin
                        state_d = S_MEM_D;
                        req_d   = 1'b1;
                        buf_inv = dbus_we_i;
                    end
                end
            end
            S_MEM_I: begin
                if (mem_ack_i) begin
                    ibus_ack_o = 1'b1;
                    ibus_dat_o = mem_dat_i;
                    buf_load   = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_MEM_D: begin
                if (mem_ack_i) begin
                    dbus_ack_o = 1'b1;
                    dbus_dat_o = mem_dat_i;
                    state_d    = S_IDLE;
                end
            end
            S_LOCAL_I: begin
                ibus_ack_o = 1'b1;
                ibus_dat_o = loc_hit_q ? buf_dat : '0;
                state_d    = S_IDLE;
            end
            S_LOCAL_D: begin
                dbus_ack_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            last_d_q  <= 1'b1;
            loc_hit_q <= 1'b0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            dat_q     <= '0;
            adr_q     <= '0;
        end else begin
            state_q   <= state_d;
            loc_hit_q <= loc_hit_d;
            if (grant) begin
                last_d_q <= grant_d;
            end
            if (req_i) begin
                sel_q <= (i_reg == REG_RAM);
                we_q  <= 1'b0;
                be_q  <= 4'hF;
                dat_q <= '0;
                adr_q <= ibus_adr_i[23:2];
            end else if (req_d) begin
                sel_q <= (d_reg == REG_RAM);
                we_q  <= dbus_we_i;
                be_q  <= dbus_be_i;
                dat_q <= dbus_dat_i;
                adr_q <= dbus_adr_i[23:2];
            end
        end
    end

    assign mem_stb_o = (state_q == S_MEM_I) || (state_q == S_MEM_D);
    assign mem_sel_o = sel_q;
    assign mem_we_o  = we_q;
    assign mem_be_o  = be_q;
    assign mem_dat_o = dat_q;
    assign mem_adr_o = adr_q;

endmodule
